// File: rtl/wrr_arb_pkg.sv
// -----------------------------------------------------------------------------
// wrr_arb_pkg
// Shared types and helpers for the weighted round-robin burst arbiter.
//   state_t       : arbiter FSM state (IDLE, GRANT)
//   idx_width()   : width of a port index for a given port count
//   weight_of()   : extracts the weight field of one port from the packed bus
// -----------------------------------------------------------------------------
package wrr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Upper bound on NUM_PORTS*WEIGHT_W; callers zero-extend their weight bus
    // to this width so one helper serves every parameterisation.
    localparam int MAX_WEIGHT_BUS = 1024;

    // A single-port index still needs one bit so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] weight_of(
        input logic [MAX_WEIGHT_BUS-1:0] bus,
        input int                        idx,
        input int                        width
    );
        logic [MAX_WEIGHT_BUS-1:0] shifted;
        shifted = bus >> (idx * width);
        return 32'(shifted) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority picker: returns the first set bit of req
// searching upward from ptr and wrapping past N-1 back to 0.
//   req  : request vector, bit i = port i
//   ptr  : port with the highest priority this cycle
//   pick : one-hot winner, all-zero when nothing is requested
//   idx  : index of the winner, 0 when nothing is requested
//   any  : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the offsets from farthest to nearest so the nearest requester
    // (smallest circular distance from ptr) is the last one written and wins.
    always_comb begin
        int p;
        p    = 0;
        idx  = '0;
        any  = 1'b0;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= N) p = p - N;
            if (req[p]) begin
                idx = IW'(p);
                any = 1'b1;
            end
        end
        if (any) pick[idx] = 1'b1;
    end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_burst_arbiter
// Weighted round-robin arbiter with burst hold. A winner keeps the grant for
// up to its programmed weight in cycles or until it drops its request; the
// rotation pointer then moves past it and the next winner is granted on the
// same edge, so back-to-back bursts have no bubble.
//   clk           : rising-edge clock
//   reset         : asynchronous active-high reset
//   request_i     : per-port request levels
//   weight_i      : packed per-port burst lengths (0 behaves as 1)
//   grant_o       : registered one-hot grant, zero when idle
//   grant_valid_o : registered, equals |grant_o
//   grant_idx_o   : registered index of the winner, 0 when idle
//   burst_rem_o   : cycles left in the burst including this one, 0 when idle
// -----------------------------------------------------------------------------
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            request_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0]   weight_i,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            grant_valid_o,
    output logic [idx_width(NUM_PORTS)-1:0] grant_idx_o,
    output logic [WEIGHT_W-1:0]             burst_rem_o
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    state_t                    state;
    logic [IDX_W-1:0]          pointer;
    logic [IDX_W-1:0]          next_ptr;
    logic [IDX_W-1:0]          pick_ptr;
    logic [NUM_PORTS-1:0]      pick;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic                      hold;
    logic [MAX_WEIGHT_BUS-1:0] weight_bus;
    logic [WEIGHT_W-1:0]       win_weight;
    logic [WEIGHT_W-1:0]       load_rem;

    assign weight_bus = MAX_WEIGHT_BUS'(weight_i);

    // The current winner keeps the grant only while it still requests and has
    // more than the present cycle left in its burst.
    assign hold     = request_i[grant_idx_o] && (burst_rem_o > WEIGHT_W'(1));
    assign next_ptr = (grant_idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_o + IDX_W'(1);

    // At a burst end the pick must already use the advanced pointer so the
    // next winner can be granted on the very same edge.
    assign pick_ptr = (state == GRANT) ? next_ptr : pointer;

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_pick (
        .req  (request_i),
        .ptr  (pick_ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Weight is read only for the port about to start a burst, so mid-burst
    // changes wait for that port's next grant.
    assign win_weight = WEIGHT_W'(weight_of(weight_bus, int'(pick_idx), WEIGHT_W));
    assign load_rem   = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

    // FSM, rotation pointer and all output registers. A burst end either
    // loads the next winner directly or falls back to IDLE with outputs zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pointer       <= '0;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            burst_rem_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state         <= GRANT;
                        grant_o       <= pick;
                        grant_valid_o <= 1'b1;
                        grant_idx_o   <= pick_idx;
                        burst_rem_o   <= load_rem;
                    end
                end
                GRANT: begin
                    if (hold) begin
                        burst_rem_o <= burst_rem_o - WEIGHT_W'(1);
                    end else begin
                        pointer <= next_ptr;
                        if (pick_any) begin
                            grant_o       <= pick;
                            grant_valid_o <= 1'b1;
                            grant_idx_o   <= pick_idx;
                            burst_rem_o   <= load_rem;
                        end else begin
                            state         <= IDLE;
                            grant_o       <= '0;
                            grant_valid_o <= 1'b0;
                            grant_idx_o   <= '0;
                            burst_rem_o   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_burst_arbiter
// Directed bench for wrr_burst_arbiter (4 ports, 4-bit weights). The driver
// pushes the hand-computed outputs expected after each edge into a queue and
// a separate monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_wrr_burst_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  request_i;
    logic [15:0] weight_i;
    logic [3:0]  grant_o;
    logic        grant_valid_o;
    logic [1:0]  grant_idx_o;
    logic [3:0]  burst_rem_o;

    typedef struct {
        logic       valid;
        logic [1:0] idx;
        logic [3:0] rem;
        int         step;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   step;

    wrr_burst_arbiter #(
        .NUM_PORTS (4),
        .WEIGHT_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .request_i     (request_i),
        .weight_i      (weight_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o),
        .burst_rem_o   (burst_rem_o)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares every output against one expected entry; grant_o is implied
    // by the expected index and valid bit.
    task automatic checkOutput(input exp_t e);
        logic [3:0] exp_grant;
        exp_grant = e.valid ? (4'b0001 << e.idx) : 4'b0000;
        total++;
        if (grant_o !== exp_grant || grant_valid_o !== e.valid ||
            grant_idx_o !== e.idx || burst_rem_o !== e.rem) begin
            bad++;
            $display("[TB] FAIL step%0d: got grant=%b valid=%b idx=%0d rem=%0d, want grant=%b valid=%b idx=%0d rem=%0d",
                     e.step, grant_o, grant_valid_o, grant_idx_o, burst_rem_o,
                     exp_grant, e.valid, e.idx, e.rem);
        end
    endtask

    // Drives one request vector, waits for the edge that samples it and
    // queues the outputs expected after that edge.
    task automatic applyStimulus(input logic [3:0] req, input logic v, input int idx, input int rem);
        exp_t e;
        request_i = req;
        @(posedge clk);
        #1;
        e.valid = v;
        e.idx   = 2'(idx);
        e.rem   = 4'(rem);
        e.step  = step;
        sb.push_back(e);
        step++;
    endtask

    // Asserts reset between edges, checks the asynchronous clear at once,
    // then releases it just after a rising edge.
    task automatic applyReset();
        exp_t e;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        e.valid = 1'b0;
        e.idx   = 2'd0;
        e.rem   = 4'd0;
        e.step  = -1;
        checkOutput(e);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pops and compares one expectation per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int rot_idx[10];
        int rot_rem[10];
        exp_t e;
        total = 0;
        bad   = 0;
        step  = 0;
        rot_idx = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        rot_rem = '{1, 2, 1, 3, 2, 1, 1, 1, 2, 1};

        // Power-up reset with no requests.
        reset     = 1'b1;
        request_i = 4'b0000;
        weight_i  = {4'd1, 4'd3, 4'd2, 4'd1};
        repeat (2) @(posedge clk);
        #1;
        e.valid = 1'b0; e.idx = 2'd0; e.rem = 4'd0; e.step = -2;
        checkOutput(e);
        reset = 1'b0;
        applyStimulus(4'b0000, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 0);

        // Weighted rotation, all ports requesting.
        for (int i = 0; i < 10; i++) applyStimulus(4'b1111, 1, rot_idx[i], rot_rem[i]);
        applyStimulus(4'b0000, 0, 0, 0);

        // Pointer sits at 2 now; reset mid-burst must clear it back to 0.
        applyStimulus(4'b1111, 1, 2, 3);
        applyStimulus(4'b1111, 1, 2, 2);
        applyReset();
        applyStimulus(4'b0110, 1, 1, 2);
        applyStimulus(4'b0110, 1, 1, 1);
        applyStimulus(4'b0000, 0, 0, 0);

        // Early release of port 0 hands over on the next edge.
        applyReset();
        weight_i = {4'd1, 4'd1, 4'd2, 4'd5};
        applyStimulus(4'b0011, 1, 0, 5);
        applyStimulus(4'b0011, 1, 0, 4);
        applyStimulus(4'b0011, 1, 0, 3);
        applyStimulus(4'b0010, 1, 1, 2);
        applyStimulus(4'b0010, 1, 1, 1);
        applyStimulus(4'b0000, 0, 0, 0);

        // Sole requester re-wins with a reloaded burst counter.
        applyReset();
        weight_i = {4'd1, 4'd2, 4'd1, 4'd1};
        for (int i = 0; i < 10; i++) applyStimulus(4'b0100, 1, 2, (i % 2 == 0) ? 2 : 1);
        applyStimulus(4'b0000, 0, 0, 0);

        // Wrap from port 3 to port 1, skipping idle ports; weight 0 acts as 1.
        applyReset();
        weight_i = {4'd0, 4'd1, 4'd1, 4'd1};
        applyStimulus(4'b1010, 1, 1, 1);
        applyStimulus(4'b1010, 1, 3, 1);
        applyStimulus(4'b1010, 1, 1, 1);
        applyStimulus(4'b1010, 1, 3, 1);
        applyStimulus(4'b0000, 0, 0, 0);

        // Weight change during a burst only affects the following burst.
        applyReset();
        weight_i = {4'd1, 4'd1, 4'd3, 4'd1};
        applyStimulus(4'b0011, 1, 0, 1);
        applyStimulus(4'b0011, 1, 1, 3);
        weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        applyStimulus(4'b0011, 1, 1, 2);
        applyStimulus(4'b0011, 1, 1, 1);
        applyStimulus(4'b0011, 1, 0, 1);
        applyStimulus(4'b0011, 1, 1, 1);
        applyStimulus(4'b0011, 1, 0, 1);
        applyStimulus(4'b0000, 0, 0, 0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
Weighted round-robin arbiter with burst hold, sharing one downstream resource between NUM_PORTS requesters. It is the successor to the single-cycle round-robin arbiter. A winner keeps the grant for up to its programmed weight in cycles, or until it drops its request. Rotation then passes to the next requester in circular order. It sits in front of any shared datapath (bus, memory port, FIFO write side) and drives that datapath's select from grant_idx_o.

Parameters:
NUM_PORTS, 4, number of requesters (>= 2)
WEIGHT_W, 4, width of each per-port weight field (max burst = 2^WEIGHT_W - 1 cycles)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
request_i  input  NUM_PORTS  per-port request level, bit i = port i
weight_i  input  NUM_PORTS*WEIGHT_W  per-port max burst length; port i uses bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static configuration
grant_o  output  NUM_PORTS  registered one-hot grant, all-zero when idle
grant_valid_o  output  1  registered, equals |grant_o
grant_idx_o  output  $clog2(NUM_PORTS)  registered index of current winner; 0 when idle
burst_rem_o  output  WEIGHT_W  registered cycles remaining in current burst, including the current cycle; 0 when idle

Behaviour:
- Reset values: grant_o=0, grant_valid_o=0, grant_idx_o=0, burst_rem_o=0, pointer=0, state=IDLE.
- Reset asserted mid-burst clears all outputs asynchronously, with no completion of the burst. After release, arbitration restarts from port 0.
- State machine has two states, IDLE and GRANT.
- Pick function: first set bit of request_i searching circularly from pointer upward (pointer, pointer+1, ... wrapping to 0).
- IDLE: if request_i != 0 at a rising edge, register the winner.
  - grant_o / grant_idx_o / grant_valid_o become valid after that edge, so latency is 1 cycle from a sampled request.
  - burst_rem_o loads the winner's weight; weight 0 is treated as 1.
  - If request_i == 0, remain IDLE.
- GRANT, at each edge with winner w:
  - request_i[w]=1 and burst_rem_o>1: hold the grant, decrement burst_rem_o. Other requests never preempt.
  - Otherwise the burst ends: request_i[w]=0 (early release) or burst_rem_o==1 (weight exhausted).
- Burst end, same edge:
  - pointer <= (w+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
  - Run the pick function with the new pointer on the current request_i, and grant back-to-back with no bubble cycle if any request is pending. The same port may win again if it is the only requester; in that case grant_o stays high continuously and burst_rem_o reloads.
  - If no request is pending, go to IDLE with all outputs zeroed.
- A continuously requesting port with weight W receives exactly W consecutive grant cycles when others are competing.
- Early release: grant_o stays high for one cycle after request_i[w] falls, because the grant is registered. The requester must not rely on that cycle.
- weight_i is sampled only when a burst starts. Changes mid-burst take effect at the next grant of that port.
- Ports whose request falls while they wait are simply skipped. There is no request latching.
- grant_o is always one-hot or zero, with no glitches, since it is fully registered.

Decomposition:
- Package wrr_arb_pkg holds:
  - state enum typedef (IDLE, GRANT);
  - localparam-style helpers for index width;
  - a function extracting weight i from the packed weight bus.
- Sub-module rr_pick: purely combinational circular priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot pick, index, any.
  - Instanced once.
- The top holds the FSM, pointer, burst counter and output registers.

Test Plan:
- Reset/idle: reset=1 for 2 cycles, then request_i=0000 -> all outputs 0; pulse reset mid-burst -> outputs 0 immediately, and the next grant goes to the lowest requester starting from port 0.
- Weighted rotation: weights {p3..p0}={1,3,2,1}, request_i=1111 held -> grant_idx sequence 0(1 cycle),1(2),2(3),3(1),0,... with no idle cycles between bursts; burst_rem_o counts down.
- Early release: weight0=5, request_i=0011; drop request_i[0] after 2 grant cycles -> port 0 granted 3 cycles (2 plus 1 registered overlap), then port 1 granted the next cycle.
- Sole requester: request_i=0100 held, weight2=2 -> grant_o=0100 continuously for 10 cycles, burst_rem_o pattern 2,1,2,1,...
- Wrap and skip: request_i=1010, pointer starting at 0 -> port 1 then port 3 then port 1; weight 0 on a port -> 1-cycle grant.
- Mid-burst weight change: change weight1 from 3 to 1 during port 1's burst -> current burst still 3 cycles, next port-1 burst 1 cycle.
